// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_pkg
// Purpose  : Shared widths and loader state type for the instruction loader.
// Revision : 1.0
// ============================================================================
package instr_loader_pkg;

    localparam int INSTR_W = 12;
    localparam int NIB_W   = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } ldr_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_if
// Purpose  : Nibble input / instruction issue bundle of the instruction loader.
// Revision : 1.0
// ============================================================================
interface instr_loader_if #(
    parameter int NIB_W   = 4,
    parameter int INSTR_W = 12,
    parameter int DEPTH   = 4
);
    logic [NIB_W-1:0]         nib_in;
    logic                     nib_valid;
    logic                     go;
    logic                     clr;
    logic [INSTR_W-1:0]       instr_out;
    logic                     instr_valid;
    logic [$clog2(DEPTH)-1:0] slot;
    logic                     busy;
    logic                     done;
    logic                     overflow;

    modport master (
        output nib_in, nib_valid, go, clr,
        input  instr_out, instr_valid, slot, busy, done, overflow
    );

    modport slave (
        input  nib_in, nib_valid, go, clr,
        output instr_out, instr_valid, slot, busy, done, overflow
    );
endinterface
`default_nettype wire

// File: rtl/instr_loader_dff.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_dff
// Purpose  : Enabled register with asynchronous active-high reset to RST_VAL.
// Revision : 1.0
// ============================================================================
module instr_loader_dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
)(
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/instr_loader_nibble_assembler.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_nibble_assembler
// Purpose  : Packs three MSB-first nibbles into one instruction word.
// Revision : 1.0
// ============================================================================
module instr_loader_nibble_assembler
    import instr_loader_pkg::*;
#(
    parameter int NIB_W = instr_loader_pkg::NIB_W
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               flush,
    input  logic [NIB_W-1:0]   nib_in,
    input  logic               nib_valid,
    output logic [3*NIB_W-1:0] word,
    output logic               word_strobe
);
    logic [1:0]       r_beat;
    logic [NIB_W-1:0] r_hi;
    logic [NIB_W-1:0] r_mid;

    // The third nibble is used straight from the pins so the word is ready in its beat.
    assign word        = {r_hi, r_mid, nib_in};
    assign word_strobe = enable & nib_valid & (r_beat == 2'd2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_beat <= 2'd0;
            r_hi   <= '0;
            r_mid  <= '0;
        end else if (flush) begin
            r_beat <= 2'd0;
        end else if (enable && nib_valid) begin
            case (r_beat)
                2'd0: begin
                    r_hi   <= nib_in;
                    r_beat <= 2'd1;
                end
                2'd1: begin
                    r_mid  <= nib_in;
                    r_beat <= 2'd2;
                end
                default: r_beat <= 2'd0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Purpose  : Buffers a short nibble-loaded program and issues it one per cycle.
// Revision : 1.0
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int INSTR_W = instr_loader_pkg::INSTR_W,
    parameter int NIB_W   = instr_loader_pkg::NIB_W,
    parameter int DEPTH   = 4
)(
    input  logic          clock,
    input  logic          reset,
    instr_loader_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(DEPTH);
    localparam logic [1:0]       ST_LOAD  = LOAD;
    localparam logic [1:0]       ST_ISSUE = ISSUE;
    localparam logic [1:0]       ST_DONE  = DONE;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_count_en;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic               r_overflow;
    logic [INSTR_W-1:0] r_mem [DEPTH];

    logic [INSTR_W-1:0] w_word;
    logic               w_word_strobe;
    logic               w_in_load;
    logic               w_write;
    logic               w_drop;
    logic               w_go_load;
    logic               w_last;
    logic               w_valid;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_write   = w_word_strobe & (r_count < C_DEPTH);
    assign w_drop    = w_word_strobe & ~(r_count < C_DEPTH);
    // A word completing in the go cycle counts, so go with an empty buffer is still legal then.
    assign w_go_load = w_in_load & bus.go & ((r_count != '0) | w_word_strobe);
    assign w_last    = ({1'b0, r_rd_ptr} == (r_count - CNT_W'(1)));

    instr_loader_nibble_assembler #(
        .NIB_W (NIB_W)
    ) u_asm (
        .clock       (clock),
        .reset       (reset),
        .enable      (w_in_load & ~bus.clr),
        .flush       (bus.clr | w_go_load),
        .nib_in      (bus.nib_in),
        .nib_valid   (bus.nib_valid),
        .word        (w_word),
        .word_strobe (w_word_strobe)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        if (bus.clr) begin
            w_state_nxt  = ST_LOAD;
            w_rd_ptr_nxt = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_go_load) begin
                        w_state_nxt  = ST_ISSUE;
                        w_rd_ptr_nxt = '0;
                    end
                end
                ST_ISSUE: begin
                    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.go) begin
                        w_state_nxt  = ST_ISSUE;
                        w_rd_ptr_nxt = '0;
                    end
                end
                default: w_state_nxt = ST_LOAD;
            endcase
        end
    end

    assign w_count_en  = bus.clr | w_write;
    assign w_count_nxt = bus.clr ? '0 : (r_count + CNT_W'(1));

    instr_loader_dff #(.W(CNT_W)) u_count (
        .clock (clock),
        .reset (reset),
        .en    (w_count_en),
        .d     (w_count_nxt),
        .q     (r_count)
    );

    instr_loader_dff #(.W(PTR_W)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .d     (w_rd_ptr_nxt),
        .q     (r_rd_ptr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_LOAD;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.clr) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_count[PTR_W-1:0]] <= w_word;
        end
    end

    assign w_valid         = (r_state == ST_ISSUE);
    assign bus.instr_valid = w_valid;
    assign bus.instr_out   = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.slot        = w_valid ? r_rd_ptr : '0;
    assign bus.busy        = w_valid;
    assign bus.done        = (r_state == ST_DONE);
    assign bus.overflow    = r_overflow;
endmodule
`default_nettype wire
